// File: rtl/axi4_lite_timer_pkg.sv
// Shared types, register map and helpers for the AXI4-Lite timer slave.
package axi4_lite_timer_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic {
        W_IDLE,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [2:0] {
        SEL_CTRL,
        SEL_LOAD,
        SEL_COUNT,
        SEL_STATUS,
        SEL_PRESCALE,
        SEL_NONE
    } reg_sel_t;

    // Register byte offsets inside the slave window
    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_LOAD     = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_STATUS   = 5'h0C;
    localparam logic [4:0] OFF_PRESCALE = 5'h10;

    // CTRL bit positions
    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;
    localparam int unsigned CTRL_W           = 3;

    // Map a word offset to a register select; anything outside the window is unmapped
    function automatic reg_sel_t decode_offset(input logic in_window, input logic [4:0] offset);
        reg_sel_t sel;
        sel = SEL_NONE;
        if (in_window) begin
            case (offset)
                OFF_CTRL:     sel = SEL_CTRL;
                OFF_LOAD:     sel = SEL_LOAD;
                OFF_COUNT:    sel = SEL_COUNT;
                OFF_STATUS:   sel = SEL_STATUS;
                OFF_PRESCALE: sel = SEL_PRESCALE;
                default:      sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // Byte-lane merge of new write data over the current register value
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) begin
                merged[8*i +: 8] = new_val[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axi4_lite_timer_slave_core.sv
// Prescaler plus down counter; reports expiry and when the enable must drop.
module timer_counter_core
    import axi4_lite_timer_pkg::*;
#(
    parameter int unsigned TIMER_W = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               auto_reload,
    input  logic               start,
    input  logic [TIMER_W-1:0] load_val,
    input  logic [PRESC_W-1:0] presc_val,
    output logic [TIMER_W-1:0] count,
    output logic               expire,
    output logic               clear_en
);

    logic [PRESC_W-1:0] presc_cnt;
    logic               tick;

    // >= rather than == so lowering PRESCALE below the running count cannot stall for a full wrap
    always_comb begin
        tick     = en && (presc_cnt >= presc_val);
        expire   = tick && (count == '0);
        clear_en = expire && !auto_reload;
    end

    // Prescaler and counter update; start reloads, en=0 freezes both
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_cnt <= '0;
            count     <= '0;
        end else if (start) begin
            presc_cnt <= '0;
            count     <= load_val;
        end else if (en) begin
            if (tick) begin
                presc_cnt <= '0;
                if (count != '0) begin
                    count <= count - TIMER_W'(1);
                end else if (auto_reload) begin
                    count <= load_val;
                end
            end else begin
                presc_cnt <= presc_cnt + PRESC_W'(1);
            end
        end
    end

endmodule

// File: rtl/axi4_lite_timer_slave.sv
// AXI4-Lite slave exposing CTRL/LOAD/COUNT/STATUS/PRESCALE of a down-counting timer.
module axi4_lite_timer_slave
    import axi4_lite_timer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMER_W = 32,
    parameter int unsigned PRESC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wvalid,
    output logic              wready,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    input  logic [ADDR_W-1:0] araddr,
    input  logic              arvalid,
    output logic              arready,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rvalid,
    input  logic              rready,
    output logic              irq
);

    wr_state_t          w_state, w_state_next;
    rd_state_t          r_state, r_state_next;

    logic [CTRL_W-1:0]  ctrl_q;
    logic [TIMER_W-1:0] load_q;
    logic [PRESC_W-1:0] presc_q;
    logic               expired_q;
    resp_t              bresp_q;
    resp_t              rresp_q;

    reg_sel_t           wr_sel, rd_sel;
    logic               wr_fire, rd_fire;
    logic [CTRL_W-1:0]  ctrl_new;
    logic               start;
    resp_t              wr_resp_val, rd_resp_val;
    logic [31:0]        rd_val;

    logic [TIMER_W-1:0] count;
    logic               expire, clear_en;
    logic               addr_lsb_unused;

    assign addr_lsb_unused = ^{awaddr[1:0], araddr[1:0]};

    timer_counter_core #(
        .TIMER_W (TIMER_W),
        .PRESC_W (PRESC_W)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (ctrl_q[CTRL_EN]),
        .auto_reload (ctrl_q[CTRL_AUTO_RELOAD]),
        .start       (start),
        .load_val    (load_q),
        .presc_val   (presc_q),
        .count       (count),
        .expire      (expire),
        .clear_en    (clear_en)
    );

    // Upper address bits must be zero, so e.g. 0x20 is unmapped instead of aliasing CTRL
    always_comb begin
        wr_sel      = decode_offset(awaddr[ADDR_W-1:5] == '0, {awaddr[4:2], 2'b00});
        rd_sel      = decode_offset(araddr[ADDR_W-1:5] == '0, {araddr[4:2], 2'b00});
        wr_resp_val = (wr_sel == SEL_COUNT || wr_sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
        ctrl_new    = CTRL_W'(apply_wstrb(32'(ctrl_q), wdata, wstrb));
        start       = wr_fire && (wr_sel == SEL_CTRL) && ctrl_new[CTRL_EN] && !ctrl_q[CTRL_EN];
    end

    // Write channel state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_next;
        end
    end

    // Write channel next state: accept only when address and data are both present
    always_comb begin
        w_state_next = w_state;
        case (w_state)
            W_IDLE:  if (awvalid && wvalid) w_state_next = W_RESP;
            W_RESP:  if (bready)            w_state_next = W_IDLE;
            default: w_state_next = W_IDLE;
        endcase
    end

    // Write channel outputs
    always_comb begin
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = awvalid && wvalid;
                wready  = awvalid && wvalid;
            end
            W_RESP:  bvalid = 1'b1;
            default: bvalid = 1'b0;
        endcase
        wr_fire = awready;
    end

    // Read channel state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_next;
        end
    end

    // Read channel next state
    always_comb begin
        r_state_next = r_state;
        case (r_state)
            R_IDLE:  if (arvalid) r_state_next = R_DATA;
            R_DATA:  if (rready)  r_state_next = R_IDLE;
            default: r_state_next = R_IDLE;
        endcase
    end

    // Read channel outputs
    always_comb begin
        arready = (r_state == R_IDLE) && arvalid;
        rvalid  = (r_state == R_DATA);
        rd_fire = arready;
    end

    // Read data mux, sampled at the accept edge
    always_comb begin
        rd_val      = '0;
        rd_resp_val = RESP_OKAY;
        case (rd_sel)
            SEL_CTRL:     rd_val = 32'(ctrl_q);
            SEL_LOAD:     rd_val = 32'(load_q);
            SEL_COUNT:    rd_val = 32'(count);
            SEL_STATUS:   rd_val = 32'(expired_q);
            SEL_PRESCALE: rd_val = 32'(presc_q);
            default:      rd_resp_val = RESP_SLVERR;
        endcase
    end

    // Register file, expiry flag and registered responses
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q    <= '0;
            load_q    <= '0;
            presc_q   <= '0;
            expired_q <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rdata     <= '0;
        end else begin
            if (wr_fire && wr_sel == SEL_CTRL) begin
                ctrl_q <= ctrl_new;
            end else if (clear_en) begin
                ctrl_q[CTRL_EN] <= 1'b0;
            end
            if (wr_fire && wr_sel == SEL_LOAD) begin
                load_q <= TIMER_W'(apply_wstrb(32'(load_q), wdata, wstrb));
            end
            if (wr_fire && wr_sel == SEL_PRESCALE) begin
                presc_q <= PRESC_W'(apply_wstrb(32'(presc_q), wdata, wstrb));
            end
            if (expire) begin
                expired_q <= 1'b1;
            end else if (wr_fire && wr_sel == SEL_STATUS && wstrb[0] && wdata[0]) begin
                expired_q <= 1'b0;
            end
            if (wr_fire) begin
                bresp_q <= wr_resp_val;
            end
            if (rd_fire) begin
                rdata   <= rd_val;
                rresp_q <= rd_resp_val;
            end
        end
    end

    assign bresp = bresp_q;
    assign rresp = rresp_q;
    assign irq   = expired_q && ctrl_q[CTRL_IRQ_EN];

endmodule
